sata_regs_bank: RTL and testbench

- Register file that consumes the memory-style register interface produced by the AXI slave buffer (bram_waddr/wdata/wstb/wen, bram_raddr/ren/regen/rdata).
- Holds the SATA host control, status, interrupt and doorbell registers.
- Drives control outputs, interrupt and command strobes into the SATA controller datapath.
- Two-stage read pipeline: bram_ren, then bram_regen, matching the read side of the AXI buffer.

---
 rtl/sata_regs_bank.sv | 144 ++++++++++++++
 tb/tb_sata_regs_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_regs_bank.sv
// sata_regs_bank: SATA host register file behind the AXI slave buffer's
// memory-style port. Holds ID, CTRL, IRQ_STAT/IRQ_MASK, STATUS, SCRATCH,
// DOORBELL and WCNT words, with a two-stage read pipeline (ren, then regen).
// Optional feature macro: SATA_REGS_WCNT_EN builds the in-range write counter
// at word 7; without it word 7 reads 0.
module sata_regs_bank #(
    parameter int unsigned ADDR_BITS = 4,
    parameter logic [31:0] ID_VALUE  = 32'h5A7A0001,
    parameter int unsigned IRQ_W     = 8
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [15:0]      bram_waddr,
    input  logic [31:0]      bram_wdata,
    input  logic [3:0]       bram_wstb,
    input  logic             bram_wen,
    input  logic [15:0]      bram_raddr,
    input  logic             bram_ren,
    input  logic             bram_regen,
    output logic [31:0]      bram_rdata,
    input  logic [31:0]      status_in,
    input  logic [IRQ_W-1:0] irq_set,
    output logic [31:0]      ctrl,
    output logic             irq,
    output logic             cmd_valid,
    output logic [31:0]      cmd_data
);

    // Valid interrupt bit positions; IRQ_W may be the full 32 bits.
    localparam logic [31:0] IRQ_BITS = (IRQ_W >= 32) ? '1 : ((32'd1 << IRQ_W) - 32'd1);

    logic        w_in_range;
    logic        r_in_range;
    logic [31:0] wmask;
    logic [31:0] irq_stat;
    logic [31:0] irq_mask;
    logic [31:0] status_q;
    logic [31:0] scratch;
    logic [31:0] stage1;
    logic [31:0] rd_val;
    logic [31:0] wcnt_val;
    logic [31:0] stat_clr;
    logic [31:0] irq_set_ext;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_mask;
    logic        wr_scratch;
    logic        wr_db;

    assign w_in_range  = (bram_waddr >> ADDR_BITS) == 16'd0;
    assign r_in_range  = (bram_raddr >> ADDR_BITS) == 16'd0;
    assign wr_ctrl     = bram_wen && w_in_range && (bram_waddr == 16'd1);
    assign wr_stat     = bram_wen && w_in_range && (bram_waddr == 16'd2);
    assign wr_mask     = bram_wen && w_in_range && (bram_waddr == 16'd3);
    assign wr_scratch  = bram_wen && w_in_range && (bram_waddr == 16'd5);
    assign wr_db       = bram_wen && w_in_range && (bram_waddr == 16'd6) && (bram_wstb != 4'd0);
    assign irq_set_ext = 32'(irq_set);
    assign stat_clr    = wr_stat ? (bram_wdata & wmask & IRQ_BITS) : '0;

    // Expand the byte strobes into a 32-bit bit mask.
    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[i*8 +: 8] = {8{bram_wstb[i]}};
        end
    end

    // Read mux over current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        if (r_in_range) begin
            case (bram_raddr)
                16'd0:   rd_val = ID_VALUE;
                16'd1:   rd_val = ctrl;
                16'd2:   rd_val = irq_stat;
                16'd3:   rd_val = irq_mask;
                16'd4:   rd_val = status_q;
                16'd5:   rd_val = scratch;
                16'd6:   rd_val = cmd_data;
                16'd7:   rd_val = wcnt_val;
                default: rd_val = '0;
            endcase
        end
    end

    // Register state, doorbell strobe, interrupt output and read pipeline.
    always_ff @(posedge aclk) begin
        if (arst) begin
            ctrl       <= '0;
            irq_stat   <= '0;
            irq_mask   <= '0;
            status_q   <= '0;
            scratch    <= '0;
            cmd_data   <= '0;
            cmd_valid  <= 1'b0;
            irq        <= 1'b0;
            stage1     <= '0;
            bram_rdata <= '0;
        end else begin
            status_q  <= status_in;
            irq       <= |(irq_stat & irq_mask);
            // Set is OR'd in after the clear so a same-cycle set survives.
            irq_stat  <= (irq_stat & ~stat_clr) | irq_set_ext;
            cmd_valid <= 1'b0;
            if (wr_ctrl) begin
                ctrl <= (ctrl & ~wmask) | (bram_wdata & wmask);
            end
            if (wr_mask) begin
                irq_mask <= ((irq_mask & ~wmask) | (bram_wdata & wmask)) & IRQ_BITS;
            end
            if (wr_scratch) begin
                scratch <= (scratch & ~wmask) | (bram_wdata & wmask);
            end
            if (wr_db) begin
                cmd_data  <= (cmd_data & ~wmask) | (bram_wdata & wmask);
                cmd_valid <= 1'b1;
            end
            if (bram_ren) begin
                stage1 <= rd_val;
            end
            if (bram_regen) begin
                bram_rdata <= stage1;
            end
        end
    end

`ifdef SATA_REGS_WCNT_EN
    logic [31:0] wcnt;

    // Count every in-range write, including writes to read-only words.
    always_ff @(posedge aclk) begin
        if (arst) begin
            wcnt <= '0;
        end else if (bram_wen && w_in_range) begin
            wcnt <= wcnt + 32'd1;
        end
    end

    assign wcnt_val = wcnt;
`else
    assign wcnt_val = '0;
`endif

endmodule

// File: tb/tb_sata_regs_bank.sv
// tb_sata_regs_bank: directed test-plan scenarios followed by randomized
// traffic, every cycle compared against a behavioural register-map model.
module tb_sata_regs_bank;

    logic        aclk = 1'b0;
    logic        arst;
    logic [15:0] bram_waddr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstb;
    logic        bram_wen;
    logic [15:0] bram_raddr;
    logic        bram_ren;
    logic        bram_regen;
    logic [31:0] bram_rdata;
    logic [31:0] status_in;
    logic [7:0]  irq_set;
    logic [31:0] ctrl;
    logic        irq;
    logic        cmd_valid;
    logic [31:0] cmd_data;

    always #5 aclk = ~aclk;

    sata_regs_bank #(
        .ADDR_BITS(4),
        .ID_VALUE (32'h5A7A0001),
        .IRQ_W    (8)
    ) dut (
        .aclk      (aclk),
        .arst      (arst),
        .bram_waddr(bram_waddr),
        .bram_wdata(bram_wdata),
        .bram_wstb (bram_wstb),
        .bram_wen  (bram_wen),
        .bram_raddr(bram_raddr),
        .bram_ren  (bram_ren),
        .bram_regen(bram_regen),
        .bram_rdata(bram_rdata),
        .status_in (status_in),
        .irq_set   (irq_set),
        .ctrl      (ctrl),
        .irq       (irq),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of the register map.
    logic [31:0] m_ctrl, m_scratch, m_status, m_cmd, m_stage1, m_rdata, m_wcnt;
    logic [7:0]  m_stat, m_mask;
    logic        m_cmdv, m_irq;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] stb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (stb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a)
            16'd0:   return 32'h5A7A0001;
            16'd1:   return m_ctrl;
            16'd2:   return {24'd0, m_stat};
            16'd3:   return {24'd0, m_mask};
            16'd4:   return m_status;
            16'd5:   return m_scratch;
            16'd6:   return m_cmd;
`ifdef SATA_REGS_WCNT_EN
            16'd7:   return m_wcnt;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        logic [31:0] rv;
        logic [7:0]  clr;
        logic        irq_n;
        if (arst) begin
            m_ctrl = '0; m_scratch = '0; m_status = '0; m_cmd = '0;
            m_stage1 = '0; m_rdata = '0; m_wcnt = '0;
            m_stat = '0; m_mask = '0; m_cmdv = 1'b0; m_irq = 1'b0;
            return;
        end
        rv    = m_read(bram_raddr);
        irq_n = |(m_stat & m_mask);
        clr   = '0;
        m_cmdv = 1'b0;
        if (bram_regen) m_rdata = m_stage1;
        if (bram_ren) m_stage1 = rv;
        if (bram_wen && bram_waddr < 16'd16) begin
            m_wcnt = m_wcnt + 32'd1;
            case (bram_waddr)
                16'd1: m_ctrl = merge(m_ctrl, bram_wdata, bram_wstb);
                16'd2: clr = merge(32'd0, bram_wdata, bram_wstb) & 32'hFF;
                16'd3: m_mask = 8'(merge({24'd0, m_mask}, bram_wdata, bram_wstb));
                16'd5: m_scratch = merge(m_scratch, bram_wdata, bram_wstb);
                16'd6: if (bram_wstb != 4'd0) begin
                    m_cmd  = merge(m_cmd, bram_wdata, bram_wstb);
                    m_cmdv = 1'b1;
                end
                default: ;
            endcase
        end
        m_stat   = (m_stat & ~clr) | irq_set;
        m_status = status_in;
        m_irq    = irq_n;
    endtask

    // One clock: model and DUT advance on the same edge, outputs compared after.
    task automatic step();
        @(posedge aclk);
        model_update();
        #1;
        check("rdata", bram_rdata, m_rdata);
        check("ctrl", ctrl, m_ctrl);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_cmdv});
        check("cmd_data", cmd_data, m_cmd);
    endtask

    task automatic idle();
        bram_wen = 1'b0; bram_ren = 1'b0; bram_regen = 1'b0; irq_set = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        bram_waddr = a; bram_wdata = d; bram_wstb = s; bram_wen = 1'b1;
        step();
        bram_wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        bram_raddr = a; bram_ren = 1'b1;
        step();
        bram_ren = 1'b0; bram_regen = 1'b1;
        step();
        bram_regen = 1'b0;
        d = bram_rdata;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        step();
        step();
        arst = 1'b0;
    endtask

    logic [31:0] d;
    int unsigned sel;

    initial begin
        arst = 1'b1;
        bram_waddr = '0; bram_wdata = '0; bram_wstb = '0; bram_raddr = '0;
        status_in = 32'h1234_5678;
        idle();
        do_reset();
        check("rst_ctrl", ctrl, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);

        // ID read with minimum latency
        rd(16'd0, d);
        check("id_read", d, 32'h5A7A0001);

        // CTRL byte-strobe merge
        wr(16'd1, 32'hFFFFFFFF, 4'hF);
        wr(16'd1, 32'h00000000, 4'b0101);
        check("ctrl_merge", ctrl, 32'hFF00FF00);
        rd(16'd1, d);
        check("ctrl_readback", d, 32'hFF00FF00);

        // Interrupt set, mask, set-beats-clear, clear
        irq_set = 8'h05;
        step();
        irq_set = '0;
        wr(16'd3, 32'h04, 4'h1);
        check("irq_mask_just_written", {31'd0, irq}, 32'd0);
        step();
        check("irq_rise", {31'd0, irq}, 32'd1);
        irq_set = 8'h04;
        wr(16'd2, 32'h04, 4'h1);
        irq_set = '0;
        step();
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        rd(16'd2, d);
        check("irq_stat_kept", d, 32'h05);
        wr(16'd2, 32'h04, 4'h1);
        step();
        check("irq_drop", {31'd0, irq}, 32'd0);
        rd(16'd3, d);
        check("irq_mask_read", d, 32'h04);

        // Back-to-back doorbells, then out-of-range write
        wr(16'd6, 32'h11, 4'hF);
        check("db1_valid", {31'd0, cmd_valid}, 32'd1);
        check("db1_data", cmd_data, 32'h11);
        wr(16'd6, 32'h22, 4'hF);
        check("db2_valid", {31'd0, cmd_valid}, 32'd1);
        check("db2_data", cmd_data, 32'h22);
        wr(16'h0016, 32'h33, 4'hF);
        check("db_oor_no_pulse", {31'd0, cmd_valid}, 32'd0);
        check("db_oor_data", cmd_data, 32'h22);

        // Read-before-write on the same cycle
        bram_waddr = 16'd5; bram_wdata = 32'hA5; bram_wstb = 4'hF; bram_wen = 1'b1;
        bram_raddr = 16'd5; bram_ren = 1'b1;
        step();
        idle();
        bram_regen = 1'b1;
        step();
        bram_regen = 1'b0;
        check("rbw_old", bram_rdata, 32'd0);
        rd(16'd5, d);
        check("rbw_new", d, 32'hA5);

        // Write counter
        do_reset();
`ifdef SATA_REGS_WCNT_EN
        wr(16'd0, 32'hDEAD, 4'hF);
        wr(16'd5, 32'h1, 4'hF);
        wr(16'd9, 32'h2, 4'hF);
        wr(16'h0020, 32'h3, 4'hF);
        rd(16'd7, d);
        check("wcnt_three", d, 32'd3);
        force dut.wcnt = 32'hFFFFFFFF;
        #1;
        release dut.wcnt;
        m_wcnt = 32'hFFFFFFFF;
        wr(16'd5, 32'h4, 4'hF);
        rd(16'd7, d);
        check("wcnt_wrap", d, 32'd0);
`else
        wr(16'd0, 32'hDEAD, 4'hF);
        wr(16'd5, 32'h1, 4'hF);
        rd(16'd7, d);
        check("wcnt_absent", d, 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            arst = ($urandom_range(0, 99) == 0);
            sel  = $urandom_range(0, 9);
            if (sel < 8)       bram_waddr = 16'(sel);
            else if (sel == 8) bram_waddr = 16'($urandom_range(8, 15));
            else               bram_waddr = 16'($urandom);
            bram_wdata = $urandom;
            bram_wstb  = 4'($urandom);
            bram_wen   = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            bram_raddr = (sel < 9) ? 16'(sel) : 16'($urandom);
            bram_ren   = ($urandom_range(0, 1) == 1);
            bram_regen = ($urandom_range(0, 1) == 1);
            irq_set    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            status_in  = $urandom;
            step();
        end
        arst = 1'b0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
